// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: one quotient bit per cycle,
// result delivered as {remainder, quotient} for direct HI/LO write-back.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]   rem, rem_n;
  logic [WIDTH-1:0]   dvd, dvd_n;
  logic [WIDTH-1:0]   dsr, dsr_n;
  logic               sgn, sgn_n;
  logic               s1, s1_n;
  logic               s2, s2_n;
  logic [2*WIDTH-1:0] result_n;
  logic               ready_n;

  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // dvd doubles as the quotient register: dividend bits shift out the top
  // while quotient bits shift in at the bottom.
  always_comb begin
    rem_sh  = {rem, dvd[WIDTH-1]};
    trial   = rem_sh - {1'b0, dsr};
    mag1    = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    mag2    = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    quo_fix = (sgn && (s1 ^ s2)) ? -dvd : dvd;
    rem_fix = (sgn && s1) ? -rem : rem;
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rem_n    = rem;
    dvd_n    = dvd;
    dsr_n    = dsr;
    sgn_n    = sgn;
    s1_n     = s1;
    s2_n     = s2;
    result_n = result_o;
    ready_n  = ready_o;
    case (state)
      IDLE: begin
        ready_n  = 1'b0;
        result_n = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_n = DIVZERO;
          end else begin
            state_n = ON;
            dvd_n   = mag1;
            dsr_n   = mag2;
            sgn_n   = signed_div_i;
            s1_n    = opdata1_i[WIDTH-1];
            s2_n    = opdata2_i[WIDTH-1];
            cnt_n   = '0;
            rem_n   = '0;
          end
        end
      end
      DIVZERO: begin
        state_n  = annul_i ? IDLE : END;
        result_n = '0;
        ready_n  = !annul_i;
      end
      ON: begin
        if (annul_i) begin
          state_n  = IDLE;
          result_n = '0;
          ready_n  = 1'b0;
        end else if (cnt == CNT_W'(WIDTH)) begin
          state_n  = END;
          result_n = {rem_fix, quo_fix};
          ready_n  = 1'b1;
        end else begin
          // trial[WIDTH] is the borrow: set means the divisor did not fit
          rem_n = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
          dvd_n = {dvd[WIDTH-2:0], ~trial[WIDTH]};
          cnt_n = cnt + 1'b1;
        end
      end
      END: begin
        if (!start_i) begin
          state_n  = IDLE;
          result_n = '0;
          ready_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      sgn      <= 1'b0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rem      <= rem_n;
      dvd      <= dvd_n;
      dsr      <= dsr_n;
      sgn      <= sgn_n;
      s1       <= s1_n;
      s2       <= s2_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: expected {rem, quo} queued at start,
// popped and compared when ready_o rises.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'h0, a};
      sb = {32'h0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Drive an operation with start held; E0 is the first edge after the call.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] exp, input int chg_at, input int drop_at,
                        output int lat, output logic [63:0] res);
    opdata1_i = a; opdata2_i = b; signed_div_i = s; start_i = 1'b1;
    exp_q.push_back(exp);
    lat = -1; res = '0;
    for (int e = 0; e < 80; e++) begin
      @(posedge clk); #1;
      if (ready_o) begin
        lat = e; res = result_o;
        return;
      end
      if (e == chg_at) begin
        opdata1_i = $urandom; opdata2_i = $urandom | 32'h1; signed_div_i = ~signed_div_i;
      end
      if (e == drop_at) start_i = 1'b0;
    end
  endtask

  task automatic end_op(output logic r, output logic [63:0] res);
    start_i = 1'b0;
    @(posedge clk); #1;
    r = ready_o; res = result_o;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b1; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (ready_o !== 1'b0 || result_o !== 64'h0) begin
        n_fail++; $display("FAIL reset: ready=%b result=%h want ready=0 result=0", ready_o, result_o);
      end
    end
    rst = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (ready_o !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: ready=%b want 0", ready_o);
    end
  endtask

  // Table of operations issued back to back; each start follows END->IDLE directly.
  task automatic test_arith();
    vec_t vecs[$];
    int lat; logic [63:0] res, exp; logic r;
    vecs.push_back('{32'd100,       32'd7,         1'b0, 64'h00000002_0000000E});
    vecs.push_back('{32'hFFFFFFF9,  32'h00000002,  1'b1, 64'hFFFFFFFF_FFFFFFFD});
    vecs.push_back('{32'h00000007,  32'hFFFFFFFE,  1'b1, 64'h00000001_FFFFFFFD});
    vecs.push_back('{32'h80000000,  32'hFFFFFFFF,  1'b1, 64'h00000000_80000000});
    vecs.push_back('{32'hFFFFFFFF,  32'h00000001,  1'b0, 64'h00000000_FFFFFFFF});
    vecs.push_back('{32'hFFFFFFF9,  32'h00000002,  1'b0, 64'h00000001_7FFFFFFC});
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b; logic s;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == 32'h0) b = 32'h3;
      s = 1'($urandom_range(0, 1));
      vecs.push_back('{a, b, s, model(a, b, s)});
    end
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, 999, 999, lat, res);
      exp = exp_q.pop_front();
      n_checks++;
      if (lat !== 33) begin
        n_fail++; $display("FAIL vec%0d latency: got %0d want 33", i, lat);
      end
      n_checks++;
      if (res !== exp) begin
        n_fail++; $display("FAIL vec%0d result: got %h want %h (a=%h b=%h s=%b)", i, res, exp, vecs[i].a, vecs[i].b, vecs[i].s);
      end
      end_op(r, res);
      n_checks++;
      if (r !== 1'b0 || res !== 64'h0) begin
        n_fail++; $display("FAIL vec%0d drop_start: ready=%b result=%h want 0/0", i, r, res);
      end
    end
  endtask

  task automatic test_divzero();
    int lat; logic [63:0] res, exp; logic r;
    for (int s = 0; s < 2; s++) begin
      run_op(32'h12345678, 32'h0, 1'(s), 64'h0, 999, 999, lat, res);
      exp = exp_q.pop_front();
      n_checks++;
      if (lat !== 1 || res !== exp) begin
        n_fail++; $display("FAIL divzero s=%0d: lat=%0d result=%h want lat=1 result=%h", s, lat, res, exp);
      end
      repeat (5) begin
        @(posedge clk); #1;
        n_checks++;
        if (ready_o !== 1'b1 || result_o !== exp) begin
          n_fail++; $display("FAIL divzero_hold s=%0d: ready=%b result=%h want 1/%h", s, ready_o, result_o, exp);
        end
      end
      end_op(r, res);
      n_checks++;
      if (r !== 1'b0 || res !== 64'h0) begin
        n_fail++; $display("FAIL divzero_drop s=%0d: ready=%b result=%h want 0/0", s, r, res);
      end
    end
  endtask

  task automatic test_annul();
    int lat, highs; logic [63:0] res, exp; logic r;
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      if (e == 9) begin annul_i = 1'b1; start_i = 1'b0; end
    end
    @(posedge clk); #1;
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_fail++; $display("FAIL annul_on: ready=%b result=%h want 0/0", ready_o, result_o);
    end
    annul_i = 1'b0;
    highs = 0;
    repeat (40) begin @(posedge clk); #1; if (ready_o) highs++; end
    n_checks++;
    if (highs !== 0) begin
      n_fail++; $display("FAIL annul_no_ready: ready high %0d cycles want 0", highs);
    end
    // annul in IDLE must block the start
    annul_i = 1'b1; start_i = 1'b1; opdata2_i = 32'd7;
    highs = 0;
    repeat (40) begin @(posedge clk); #1; if (ready_o) highs++; end
    n_checks++;
    if (highs !== 0) begin
      n_fail++; $display("FAIL annul_idle: ready high %0d cycles want 0", highs);
    end
    annul_i = 1'b0; start_i = 1'b0;
    @(posedge clk); #1;
    // annul in DIVZERO
    opdata2_i = 32'h0; start_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_fail++; $display("FAIL annul_divzero: ready=%b result=%h want 0/0", ready_o, result_o);
    end
    annul_i = 1'b0;
    run_op(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 999, 999, lat, res);
    exp = exp_q.pop_front();
    n_checks++;
    if (lat !== 33 || res !== exp) begin
      n_fail++; $display("FAIL annul_restart: lat=%0d result=%h want lat=33 result=%h", lat, res, exp);
    end
    end_op(r, res);
  endtask

  task automatic test_rst_mid();
    int lat; logic [63:0] res, exp; logic r;
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (e == 19) begin rst = 1'b1; start_i = 1'b0; end
    end
    @(posedge clk); #1;
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      n_fail++; $display("FAIL rst_mid: ready=%b result=%h want 0/0", ready_o, result_o);
    end
    rst = 1'b0;
    run_op(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 999, 999, lat, res);
    exp = exp_q.pop_front();
    n_checks++;
    if (lat !== 33 || res !== exp) begin
      n_fail++; $display("FAIL rst_restart: lat=%0d result=%h want lat=33 result=%h", lat, res, exp);
    end
    end_op(r, res);
  endtask

  task automatic test_operand_change();
    int lat; logic [63:0] res, exp; logic r;
    run_op(32'hFFFFFF9C, 32'h00000007, 1'b1, model(32'hFFFFFF9C, 32'h7, 1'b1), 5, 999, lat, res);
    exp = exp_q.pop_front();
    n_checks++;
    if (lat !== 33 || res !== exp) begin
      n_fail++; $display("FAIL operand_change: lat=%0d result=%h want lat=33 result=%h", lat, res, exp);
    end
    end_op(r, res);
    // start dropped mid-division: must still complete, then fall to IDLE
    run_op(32'd1000, 32'd33, 1'b0, model(32'd1000, 32'd33, 1'b0), 999, 3, lat, res);
    exp = exp_q.pop_front();
    n_checks++;
    if (lat !== 33 || res !== exp) begin
      n_fail++; $display("FAIL start_drop_on: lat=%0d result=%h want lat=33 result=%h", lat, res, exp);
    end
    end_op(r, res);
    n_checks++;
    if (r !== 1'b0 || res !== 64'h0) begin
      n_fail++; $display("FAIL start_drop_end: ready=%b result=%h want 0/0", r, res);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_divzero();
    test_annul();
    test_rst_mid();
    test_operand_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
